// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the profile-sequenced clock divider.
// Provides the widths, reset profile, FSM encoding and the circular next-entry search.
package div_ctrl_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NPROF = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned REP_W = 8;

  localparam logic [CNT_W-1:0] DEF_PERIOD = 16'd4245;
  localparam logic [CNT_W-1:0] DEF_HIGH   = 16'd849;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } sched_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [REP_W-1:0] reps;
  } profile_t;

  // Returns {found, idx}: the first set bit of mask at or after 'first', wrapping around.
  function automatic logic [IDX_W:0] find_active(input logic [NPROF-1:0] mask,
                                                 input logic [IDX_W-1:0] first);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] idx;
    logic             found;
    found = 1'b0;
    idx   = first;
    for (int k = 0; k < NPROF; k++) begin
      cand = first + IDX_W'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/prog_div_core.sv
// Loadable period counter producing a registered divided clock and end-of-period pulse.
// Outputs are computed from the next counter value so they line up with the cycle they describe.
module prog_div_core
  import div_ctrl_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic             halt,
  input  logic [CNT_W-1:0] load_period,
  input  logic [CNT_W-1:0] load_high,
  output logic             clk_out,
  output logic             period_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    high_d   = high_q;
    clk_d    = clk_q;
    tick_d   = tick_q;
    if (halt) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end else if (load) begin
      cnt_d    = '0;
      period_d = load_period;
      high_d   = load_high;
      clk_d    = (load_high != '0);
      tick_d   = (load_period == CNT_W'(1));
    end else if (advance) begin
      cnt_d  = cnt_q + CNT_W'(1);
      clk_d  = (cnt_d < high_q);
      tick_d = (cnt_d == period_q - CNT_W'(1));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out     = clk_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/div_profile_sched.sv
// Profile table, config validation and run/drain sequencing for the programmable divider.
// Every period end reloads the core from the table, so edits land only on period boundaries.
module div_profile_sched
  import div_ctrl_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             period_tick,
  output logic [IDX_W-1:0] prof_idx,
  output logic             busy,
  output logic             cfg_err
);

  profile_t         table_q [NPROF];
  sched_state_e     state_q, state_d;
  logic [REP_W-1:0] rep_left_q, rep_d;
  logic [IDX_W-1:0] prof_idx_q;
  logic             cfg_err_q;

  logic [NPROF-1:0] nz_mask;
  logic [IDX_W:0]   start_hit, next_hit;
  logic [IDX_W-1:0] load_idx;
  logic             core_load, core_adv, core_halt, start_err;
  logic             cfg_wr, cfg_legal;

  always_comb begin
    for (int k = 0; k < NPROF; k++) nz_mask[k] = (table_q[k].reps != '0);
  end

  assign start_hit = find_active(nz_mask, '0);
  assign next_hit  = find_active(nz_mask, prof_idx_q + IDX_W'(1));

  assign cfg_ready = ~period_tick;
  assign cfg_wr    = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_left_q;
    load_idx  = prof_idx_q;
    core_load = 1'b0;
    core_adv  = 1'b0;
    core_halt = 1'b0;
    start_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_hit[IDX_W]) begin
            load_idx  = start_hit[IDX_W-1:0];
            rep_d     = table_q[load_idx].reps;
            core_load = 1'b1;
            state_d   = StRun;
          end else begin
            start_err = 1'b1;
          end
        end
      end
      StRun: begin
        if (period_tick) begin
          if (stop) begin
            // Stop on the last cycle of a period: nothing left to drain.
            core_halt = 1'b1;
            state_d   = StIdle;
          end else begin
            core_load = 1'b1;
            if (rep_left_q > REP_W'(1)) begin
              rep_d = rep_left_q - REP_W'(1);
            end else if (next_hit[IDX_W]) begin
              load_idx = next_hit[IDX_W-1:0];
              rep_d    = table_q[load_idx].reps;
            end else begin
              // Table emptied while running: keep cycling the current entry.
              rep_d = REP_W'(1);
            end
          end
        end else begin
          core_adv = 1'b1;
          if (stop) state_d = StDrain;
        end
      end
      StDrain: begin
        if (period_tick) begin
          core_halt = 1'b1;
          state_d   = StIdle;
        end else begin
          core_adv = 1'b1;
        end
      end
      default: begin
        core_halt = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StIdle;
      rep_left_q <= '0;
      prof_idx_q <= '0;
      cfg_err_q  <= 1'b0;
      for (int k = 1; k < NPROF; k++) table_q[k] <= '0;
      table_q[0] <= '{period: DEF_PERIOD, high: DEF_HIGH, reps: REP_W'(1)};
    end else begin
      state_q    <= state_d;
      rep_left_q <= rep_d;
      cfg_err_q  <= (cfg_wr && !cfg_legal) || start_err;
      if (core_load) prof_idx_q <= load_idx;
      if (cfg_wr && cfg_legal) begin
        table_q[cfg_idx] <= '{period: cfg_period, high: cfg_high, reps: cfg_reps};
      end
    end
  end

  prog_div_core u_core (
    .clk_in      (clk_in),
    .rst         (rst),
    .load        (core_load),
    .advance     (core_adv),
    .halt        (core_halt),
    .load_period (table_q[load_idx].period),
    .load_high   (table_q[load_idx].high),
    .clk_out     (clk_out),
    .period_tick (period_tick)
  );

  assign prof_idx = prof_idx_q;
  assign busy     = (state_q != StIdle);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_div_profile_sched.sv
// Directed bench for div_profile_sched: defaults, profile sequencing, rejects, drain, reset, live edits.
module tb_div_profile_sched;
  import div_ctrl_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic [REP_W-1:0] cfg_reps = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clk_out;
  logic             period_tick;
  logic [IDX_W-1:0] prof_idx;
  logic             busy;
  logic             cfg_err;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  div_profile_sched dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_idx     (cfg_idx),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_reps    (cfg_reps),
    .start       (start),
    .stop        (stop),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .prof_idx    (prof_idx),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input int per, input int hi,
                           input int reps);
    cfg_valid  = 1'b1;
    cfg_idx    = idx;
    cfg_period = CNT_W'(per);
    cfg_high   = CNT_W'(hi);
    cfg_reps   = REP_W'(reps);
    step();
    cfg_valid  = 1'b0;
  endtask

  // Starts on the first cycle of a period; returns high cycles and length up to the tick.
  task automatic measure_period(output int hi, output int len);
    hi  = 0;
    len = 0;
    for (int n = 0; n < 6000; n++) begin
      if (clk_out) hi++;
      len++;
      if (period_tick) begin
        step();
        return;
      end
      step();
    end
    len = -1;
  endtask

  initial begin
    int hi, len, n;
    logic [35:0] got_clk, got_tick, got_idx0, got_idx1;

    // Reset state
    step();
    step();
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_tick", period_tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_prof_idx", prof_idx, 2'd0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    step();

    // Defaults: 849 high / 4245 period
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_latency_clk", clk_out, 1'b1);
    check("t1_busy", busy, 1'b1);
    measure_period(hi, len);
    check("t1_high_a", hi, 849);
    check("t1_len_a", len, 4245);
    measure_period(hi, len);
    check("t1_high_b", hi, 849);
    check("t1_len_b", len, 4245);
    stop = 1'b1;
    step();
    stop = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      step();
      n++;
    end
    check("t1_drain_busy", busy, 1'b0);
    check("t1_drain_clk", clk_out, 1'b0);

    // Two-profile sequence 1H4L,1H4L,3H5L
    cfg_write(2'd0, 5, 1, 2);
    check("t2_wr0_err", cfg_err, 1'b0);
    cfg_write(2'd1, 8, 3, 1);
    check("t2_wr1_err", cfg_err, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      got_clk[i]  = clk_out;
      got_tick[i] = period_tick;
      got_idx0[i] = prof_idx[0];
      got_idx1[i] = prof_idx[1];
      step();
    end
    check("t2_clk_pattern", got_clk, {18'h01C21, 18'h01C21});
    check("t2_tick_pattern", got_tick, {18'h20210, 18'h20210});
    check("t2_idx_bit0", got_idx0, {18'h3FC00, 18'h3FC00});
    check("t2_idx_bit1", got_idx1, 36'h0);

    // Stop at cnt=2 of a 5-cycle period
    step();
    step();
    check("t4_cnt2_clk", clk_out, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_drain_busy", busy, 1'b1);
    check("t4_drain_no_tick", period_tick, 1'b0);
    step();
    check("t4_last_tick", period_tick, 1'b1);
    check("t4_last_busy", busy, 1'b1);
    check("t4_tick_ready", cfg_ready, 1'b0);
    step();
    check("t4_idle_busy", busy, 1'b0);
    check("t4_idle_clk", clk_out, 1'b0);
    check("t4_idle_tick", period_tick, 1'b0);
    check("t4_idle_ready", cfg_ready, 1'b1);

    // Illegal writes and start with an empty table
    cfg_write(2'd2, 4, 4, 1);
    check("t3_bad_hi_err", cfg_err, 1'b1);
    step();
    check("t3_err_pulse_ends", cfg_err, 1'b0);
    cfg_write(2'd2, 6, 0, 1);
    check("t3_zero_hi_err", cfg_err, 1'b1);
    cfg_write(2'd0, 5, 1, 0);
    check("t3_zero_e0_err", cfg_err, 1'b0);
    cfg_write(2'd1, 8, 3, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_start_err", cfg_err, 1'b1);
    check("t3_start_idle", busy, 1'b0);
    check("t3_start_clk", clk_out, 1'b0);

    // Start+stop together in IDLE; live edit of the active entry
    cfg_write(2'd3, 6, 2, 1);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t6_start_wins_busy", busy, 1'b1);
    check("t6_prof_idx", prof_idx, 2'd3);
    check("t6_first_clk", clk_out, 1'b1);
    step();
    cfg_write(2'd3, 4, 3, 1);
    check("t6_edit_err", cfg_err, 1'b0);
    check("t6_old_high_kept", clk_out, 1'b0);
    step();
    step();
    step();
    check("t6_old_len_tick", period_tick, 1'b1);
    check("t6_tick_ready", cfg_ready, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      got_clk[i]  = clk_out;
      got_tick[i] = period_tick;
      step();
    end
    check("t6_new_clk", got_clk[3:0], 4'b0111);
    check("t6_new_tick", got_tick[3:0], 4'b1000);
    check("t6_idx_after", prof_idx, 2'd3);

    // Reset mid-run restores defaults
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_clk", clk_out, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_prof_idx", prof_idx, 2'd0);
    check("t5_ready", cfg_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_restart_idx", prof_idx, 2'd0);
    measure_period(hi, len);
    check("t5_def_high", hi, 849);
    check("t5_def_len", len, 4245);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
